// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types for the UART byte scheduler: channel ids, FSM states and
// the channel tag values carried in bits [1:0] of the formatted bytes.
package kitchen_pkg;

  typedef enum logic [1:0] {
    CH_GAME    = 2'd0,
    CH_TARGET  = 2'd1,
    CH_OPERATE = 2'd2
  } ch_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [1:0] TAG_GAME    = 2'b01;
  localparam logic [1:0] TAG_OPERATE = 2'b10;
  localparam logic [1:0] TAG_TARGET  = 2'b11;

  localparam int NUM_CH = 3;

  // Width of a counter that must be able to hold the value n; never zero.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte-stream bundle between the command producers, the scheduler and the UART.
interface uart_tx_scheduler_if;

  logic [7:0] game_state;
  logic [7:0] target;
  logic [7:0] operate;
  logic       enable;
  logic       tx_done;
  logic [7:0] tx_bits;
  logic       tx_valid;
  logic       busy;
  logic       timeout_err;

  modport master (
    output game_state, target, operate, enable, tx_done,
    input  tx_bits, tx_valid, busy, timeout_err
  );

  modport slave (
    input  game_state, target, operate, enable, tx_done,
    output tx_bits, tx_valid, busy, timeout_err
  );

endinterface

// File: rtl/uart_tx_scheduler_change_detect.sv
// Per-channel pending flag: set when the input has differed from last_sent
// for two consecutive samples, so a change that reverts in time is never sent.
module change_detect (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic [7:0] i_last_sent,
  input  logic       i_wr,
  input  logic [7:0] i_wr_data,
  output logic       o_pending
);

  logic       r_pending;
  logic [7:0] w_ref;

  // Compare against the value last_sent will hold after this edge.
  assign w_ref = i_wr ? i_wr_data : i_last_sent;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= (i_data != w_ref);
    end
  end

  assign o_pending = r_pending && (i_data != i_last_sent);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrated, change-driven single-byte sender for the UART, with keep-alive
// resend of the target byte and a transmit timeout.
module uart_tx_scheduler
  import kitchen_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int REFRESH_CYCLES = 16384,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clock,
  input  logic                reset,
  uart_tx_scheduler_if.slave  bus
);

  localparam int GW = cnt_width(GAP_CYCLES);
  localparam int RW = cnt_width(REFRESH_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_CYCLES);

  state_e          r_state;
  ch_e             r_cur_ch;
  logic [7:0]      r_tx_bits;
  logic            r_timeout_err;
  logic [7:0]      r_last_sent [NUM_CH];
  logic [GW-1:0]   r_gap_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic [RW-1:0]   r_ref_cnt;

  logic [7:0]        w_in [NUM_CH];
  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_any;
  logic              w_done_ok;
  logic              w_refresh_due;
  ch_e               w_win;

  assign w_in[0] = bus.game_state;
  assign w_in[1] = bus.target;
  assign w_in[2] = bus.operate;

  assign w_done_ok     = (r_state == ST_SEND) && bus.tx_done;
  assign w_any         = |w_pending;
  assign w_refresh_due = (REFRESH_CYCLES != 0) && (r_ref_cnt == REF_MAX);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_wr[gi] = w_done_ok && (r_cur_ch == 2'(gi));

      change_detect u_cd (
        .clock       (clock),
        .reset       (reset),
        .i_data      (w_in[gi]),
        .i_last_sent (r_last_sent[gi]),
        .i_wr        (w_wr[gi]),
        .i_wr_data   (r_tx_bits),
        .o_pending   (w_pending[gi])
      );
    end
  endgenerate

  // Fixed priority: game_state, then target, then operate.
  always_comb begin
    w_win = CH_OPERATE;
    if (w_pending[0]) begin
      w_win = CH_GAME;
    end else if (w_pending[1]) begin
      w_win = CH_TARGET;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) r_last_sent[c] <= 8'h00;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr[c]) r_last_sent[c] <= r_tx_bits;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cur_ch      <= CH_GAME;
      r_tx_bits     <= 8'h00;
      r_timeout_err <= 1'b0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= '0;
      r_ref_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.enable && w_any) begin
            r_tx_bits <= w_in[w_win];
            r_cur_ch  <= w_win;
            r_to_cnt  <= '0;
            r_ref_cnt <= '0;
            r_state   <= ST_SEND;
          end else if (bus.enable && w_refresh_due) begin
            r_tx_bits <= bus.target;
            r_cur_ch  <= CH_TARGET;
            r_to_cnt  <= '0;
            r_ref_cnt <= '0;
            r_state   <= ST_SEND;
          end else if (!w_any && (r_ref_cnt != REF_MAX)) begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (bus.tx_done) begin
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end else if (r_to_cnt == TO_LAST) begin
            // Abandon the byte; last_sent is untouched so the channel retries.
            r_timeout_err <= 1'b1;
            r_gap_cnt     <= '0;
            r_state       <= ST_GAP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_bits     = r_tx_bits;
  assign bus.tx_valid    = (r_state == ST_SEND);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a cycle-level behavioural model is
// compared against the outputs every cycle, plus hand-computed literal checks.
module tb_uart_tx_scheduler;

  localparam int GAP     = 4;
  localparam int REFRESH = 64;
  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_on = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(
    .GAP_CYCLES     (GAP),
    .REFRESH_CYCLES (REFRESH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outputs derived from the rules with plain counters.
  logic [7:0] m_ls [3];
  bit         m_diff_prev [3];
  bit         m_sending;
  int         m_age;
  int         m_gap_left;
  int         m_quiet;
  int         m_ch;
  logic [7:0] m_bits;
  bit         m_err;

  always @(posedge clk) begin : model
    logic [7:0] in_now [3];
    bit         pend [3];
    int         win;
    in_now[0] = bus.game_state;
    in_now[1] = bus.target;
    in_now[2] = bus.operate;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_ls[c] = 8'h00;
        m_diff_prev[c] = 1'b0;
      end
      m_sending = 1'b0; m_age = 0; m_gap_left = 0; m_quiet = 0;
      m_ch = 0; m_bits = 8'h00; m_err = 1'b0;
    end else begin
      win = -1;
      for (int c = 2; c >= 0; c--) begin
        pend[c] = m_diff_prev[c] && (in_now[c] != m_ls[c]);
        if (pend[c]) win = c;
      end
      if (m_sending) begin
        if (bus.tx_done) begin
          m_ls[m_ch] = m_bits;
          m_sending = 1'b0;
          m_gap_left = GAP;
        end else if (m_age == TIMEOUT) begin
          m_err = 1'b1;
          m_sending = 1'b0;
          m_gap_left = GAP;
        end else begin
          m_age++;
        end
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end else if (bus.enable && win >= 0) begin
        m_sending = 1'b1; m_age = 1; m_ch = win; m_bits = in_now[win]; m_quiet = 0;
      end else if (bus.enable && REFRESH != 0 && m_quiet == REFRESH) begin
        m_sending = 1'b1; m_age = 1; m_ch = 1; m_bits = in_now[1]; m_quiet = 0;
      end else if (win < 0 && m_quiet < REFRESH) begin
        m_quiet++;
      end
      for (int c = 0; c < 3; c++) m_diff_prev[c] = (in_now[c] != m_ls[c]);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_tx_bits", 32'(bus.tx_bits), 32'(m_bits));
      check("model_tx_valid", 32'(bus.tx_valid), 32'(m_sending));
      check("model_busy", 32'(bus.busy), 32'(m_sending || (m_gap_left > 0)));
      check("model_timeout_err", 32'(bus.timeout_err), 32'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic zero_inputs();
    bus.game_state = 8'h00;
    bus.target     = 8'h00;
    bus.operate    = 8'h00;
    bus.enable     = 1'b1;
    bus.tx_done    = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [7:0] exp);
    int n;
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    check({name, "_seen"}, 32'(bus.tx_valid), 32'd1);
    check({name, "_bits"}, 32'(bus.tx_bits), 32'(exp));
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick(1);
    bus.tx_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    zero_inputs();
    tick(3);
    chk_on = 1'b1;

    // Reset values and basic latency / gap length.
    do_reset();
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_tx_bits", 32'(bus.tx_bits), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    bus.game_state = 8'h05;
    tick(1);
    check("lat1_tx_valid", 32'(bus.tx_valid), 32'd0);
    tick(1);
    check("lat2_tx_valid", 32'(bus.tx_valid), 32'd1);
    check("lat2_tx_bits", 32'(bus.tx_bits), 32'h05);
    pulse_done();
    check("done_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("done_busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      tick(1);
    end
    check("gap_len", 32'(n), 32'd4);
    pulse_done();
    check("stray_done_busy", 32'(bus.busy), 32'd0);

    // A change that reverts before arbitration sends nothing.
    bus.operate = 8'h22;
    tick(1);
    bus.operate = 8'h00;
    n = 0;
    repeat (6) begin
      tick(1);
      if (bus.tx_valid === 1'b1) n++;
    end
    check("revert_no_send", 32'(n), 32'd0);

    // Simultaneous change on all channels: priority order.
    zero_inputs();
    do_reset();
    bus.game_state = 8'h05; bus.target = 8'h0B; bus.operate = 8'h06;
    wait_valid("prio0", 8'h05); pulse_done();
    wait_valid("prio1", 8'h0B); pulse_done();
    wait_valid("prio2", 8'h06); pulse_done();

    // Target changes while its byte is in flight.
    zero_inputs();
    do_reset();
    bus.target = 8'h0B;
    wait_valid("chg_a", 8'h0B);
    bus.target = 8'h0F;
    tick(2);
    check("chg_hold_bits", 32'(bus.tx_bits), 32'h0B);
    pulse_done();
    wait_valid("chg_b", 8'h0F);
    pulse_done();

    // Timeout after exactly TIMEOUT cycles in SEND, then retry.
    zero_inputs();
    do_reset();
    bus.game_state = 8'h05;
    wait_valid("to_first", 8'h05);
    tick(TIMEOUT - 1);
    check("to_before_err", 32'(bus.timeout_err), 32'd0);
    check("to_before_valid", 32'(bus.tx_valid), 32'd1);
    tick(1);
    check("to_err", 32'(bus.timeout_err), 32'd1);
    check("to_valid_drop", 32'(bus.tx_valid), 32'd0);
    wait_valid("to_retry", 8'h05);
    pulse_done();
    check("to_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Keep-alive refresh of the target byte.
    zero_inputs();
    do_reset();
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    check("refresh_first_delay", 32'(n), 32'd65);
    check("refresh_first_bits", 32'(bus.tx_bits), 32'h00);
    pulse_done();
    n = 0;
    while (bus.tx_valid !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    check("refresh_period", 32'(n), 32'd69);
    pulse_done();
    bus.enable = 1'b0;
    n = 0;
    repeat (200) begin
      tick(1);
      if (bus.tx_valid === 1'b1) n++;
    end
    check("refresh_disabled", 32'(n), 32'd0);
    bus.enable = 1'b1;
    tick(1);
    check("refresh_on_enable", 32'(bus.tx_valid), 32'd1);
    pulse_done();

    // Reset while a byte is in flight; full sequence re-sent afterwards.
    zero_inputs();
    do_reset();
    bus.game_state = 8'h05; bus.target = 8'h0B; bus.operate = 8'h06;
    wait_valid("rsend_pre", 8'h05);
    rst = 1'b1;
    tick(1);
    check("rsend_valid_drop", 32'(bus.tx_valid), 32'd0);
    tick(1);
    rst = 1'b0;
    wait_valid("rsend0", 8'h05); pulse_done();
    wait_valid("rsend1", 8'h0B); pulse_done();
    wait_valid("rsend2", 8'h06); pulse_done();
    tick(8);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
